// File: rtl/period_error_detector.sv
// Period error detector: synchronises the capture trigger, forms saved - target as a signed
// error, and runs a lock-detect FSM plus a missing-trigger watchdog.
module period_error_detector #(
    parameter int unsigned WIDTH        = 20,
    parameter int unsigned LOCK_TOL     = 4,
    parameter int unsigned LOCK_COUNT   = 8,
    parameter int unsigned UNLOCK_COUNT = 4,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic             fpga_clk_i,
    input  logic             reset_n_i,
    input  logic             trigger_i,
    input  logic [WIDTH-1:0] counter_val_saved_i,
    input  logic [WIDTH-1:0] target_count_i,
    output logic [WIDTH:0]   error_o,
    output logic             error_valid_o,
    output logic             locked_o,
    output logic [1:0]       state_o,
    output logic             stall_o
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
    localparam logic [7:0] LockCnt = 8'(LOCK_COUNT);
    localparam logic [7:0] UnlockCnt = 8'(UNLOCK_COUNT);
    localparam logic [WIDTH:0] Tol = (WIDTH + 1)'(LOCK_TOL);

    typedef enum logic [1:0] {
        StUnlocked  = 2'd0,
        StAcquiring = 2'd1,
        StLocked    = 2'd2,
        StLosing    = 2'd3
    } state_e;

    logic [2:0]     sync_q;
    logic           trig_edge;
    logic [WIDTH:0] error_d, error_q;
    logic           valid_q;
    logic [WdW-1:0] wd_d, wd_q;
    logic           stall_d, stall_q;
    logic           timeout_hit;
    logic [WIDTH:0] err_mag;
    logic           in_tol;
    state_e         state_d, state_q;
    logic [7:0]     cnt_d, cnt_q;
    logic [7:0]     cnt_inc;

    // s2 starts at 0, so a trigger already high at reset release still yields one edge
    assign trig_edge = sync_q[1] & ~sync_q[2];
    assign error_d   = {1'b0, counter_val_saved_i} - {1'b0, target_count_i};

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q  <= '0;
            error_q <= '0;
            valid_q <= 1'b0;
            wd_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], trigger_i};
            valid_q <= trig_edge;
            if (trig_edge) begin
                error_q <= error_d;
            end
            wd_q    <= wd_d;
            stall_q <= stall_d;
        end
    end

    // An edge always wins over a coincident timeout; the count saturates at TIMEOUT.
    always_comb begin
        wd_d        = wd_q;
        stall_d     = stall_q;
        timeout_hit = 1'b0;
        if (trig_edge) begin
            wd_d    = '0;
            stall_d = 1'b0;
        end else if (wd_q != WdMax) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WdLast) begin
                stall_d     = 1'b1;
                timeout_hit = 1'b1;
            end
        end
    end

    assign err_mag = error_q[WIDTH] ? (~error_q + 1'b1) : error_q;
    assign in_tol  = (err_mag <= Tol);
    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StUnlocked;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (timeout_hit) begin
            state_d = StUnlocked;
            cnt_d   = '0;
        end else if (valid_q) begin
            unique case (state_q)
                StUnlocked: begin
                    cnt_d = '0;
                    if (in_tol) begin
                        if (LockCnt == 8'd1) begin
                            state_d = StLocked;
                        end else begin
                            state_d = StAcquiring;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                StAcquiring: begin
                    if (!in_tol) begin
                        state_d = StUnlocked;
                        cnt_d   = '0;
                    end else if (cnt_inc == LockCnt) begin
                        state_d = StLocked;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StLocked: begin
                    cnt_d = '0;
                    if (!in_tol) begin
                        if (UnlockCnt == 8'd1) begin
                            state_d = StUnlocked;
                        end else begin
                            state_d = StLosing;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                StLosing: begin
                    if (in_tol) begin
                        state_d = StLocked;
                        cnt_d   = '0;
                    end else if (cnt_inc == UnlockCnt) begin
                        state_d = StUnlocked;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StUnlocked;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        error_o       = error_q;
        error_valid_o = valid_q;
        state_o       = state_q;
        locked_o      = (state_q == StLocked) || (state_q == StLosing);
        stall_o       = stall_q;
    end

endmodule
